arcade_input_ctrl: RTL and testbench

ARCADE_INPUT_CTRL -- requirements
Module: arcade_input_ctrl

---
 rtl/arcade_input_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_arcade_input_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_ctrl.sv
// Arcade input front end: PS/2 key latches + joystick merge, rotation, SOCD, coin pulse stretch.
// Latency: joystick/rot/socd -> 1 edge, key event -> 2 edges; no backpressure (level outputs).
module arcade_input_ctrl #(
    parameter int          PLAYERS    = 2,
    parameter logic [15:0] COIN_PULSE = 16'd50000,
    parameter int          ACTIVE_LOW = 1,
    parameter int          SHARED_JOY = 1
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic [10:0]            ps2_key,
    input  logic                   kbd_clear,
    input  logic [16*PLAYERS-1:0]  joystick,
    input  logic [1:0]             rot,
    input  logic                   socd,
    output logic [4*PLAYERS-1:0]   dir_o,
    output logic [PLAYERS-1:0]     fire_o,
    output logic [PLAYERS-1:0]     start_o,
    output logic [1:0]             coin_o
);

    localparam logic INV  = (ACTIVE_LOW != 0);
    localparam int   NKEY = 17;

    localparam logic [4:0] K_P1U = 5'd0,  K_P1D = 5'd1,  K_P1L = 5'd2,  K_P1R = 5'd3;
    localparam logic [4:0] K_P1FA = 5'd4, K_P1FB = 5'd5;
    localparam logic [4:0] K_P2U = 5'd6,  K_P2D = 5'd7,  K_P2L = 5'd8,  K_P2R = 5'd9, K_P2F = 5'd10;
    localparam logic [4:0] K_S1A = 5'd11, K_S1B = 5'd12, K_S2A = 5'd13, K_S2B = 5'd14;
    localparam logic [4:0] K_C0 = 5'd15,  K_C1 = 5'd16;

    typedef enum logic {C_IDLE, C_ACTIVE} coin_st_t;

    logic            tog_q;
    logic            armed_q;
    logic [NKEY-1:0] key_q;
    logic            key_evt;
    logic            key_hit;
    logic [4:0]      key_idx;

    logic [15:0]          joy_any;
    logic                 unused_joy;
    logic [4*PLAYERS-1:0] dir_nx;
    logic [PLAYERS-1:0]   fire_nx;
    logic [PLAYERS-1:0]   start_nx;

    logic [1:0]  coin_req;
    logic [1:0]  req_q;
    coin_st_t    st_q  [2];
    coin_st_t    st_d  [2];
    logic [15:0] cnt_q [2];
    logic [15:0] cnt_d [2];

    // armed_q stays low for the first edge after reset so a held toggle bit is absorbed
    assign key_evt = armed_q && (ps2_key[10] != tog_q);

    always_comb begin
        key_hit = 1'b1;
        key_idx = K_P1U;
        case ({ps2_key[8], ps2_key[7:0]})
            9'h175:  key_idx = K_P1U;
            9'h172:  key_idx = K_P1D;
            9'h16B:  key_idx = K_P1L;
            9'h174:  key_idx = K_P1R;
            9'h029:  key_idx = K_P1FA;
            9'h014:  key_idx = K_P1FB;
            9'h02D:  key_idx = K_P2U;
            9'h02B:  key_idx = K_P2D;
            9'h023:  key_idx = K_P2L;
            9'h034:  key_idx = K_P2R;
            9'h01C:  key_idx = K_P2F;
            9'h016:  key_idx = K_S1A;
            9'h005:  key_idx = K_S1B;
            9'h01E:  key_idx = K_S2A;
            9'h006:  key_idx = K_S2B;
            9'h02E:  key_idx = K_C0;
            9'h036:  key_idx = K_C1;
            default: key_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            tog_q   <= 1'b0;
            armed_q <= 1'b0;
            key_q   <= '0;
        end else begin
            tog_q   <= ps2_key[10];
            armed_q <= 1'b1;
            if (kbd_clear)
                key_q <= '0;
            else if (key_evt && key_hit)
                key_q[key_idx] <= ps2_key[9];
        end
    end

    always_comb begin
        joy_any = '0;
        for (int p = 0; p < PLAYERS; p++)
            joy_any = joy_any | joystick[16*p +: 16];
    end

    assign unused_joy = ^joy_any;

    always_comb begin
        logic [5:0] word;
        logic [3:0] raw;
        logic [3:0] rd;
        logic       fire;
        logic       st;
        dir_nx   = '0;
        fire_nx  = '0;
        start_nx = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            word = (SHARED_JOY != 0) ? joy_any[5:0] : joystick[16*p +: 6];
            // joystick is {up,down,left,right} at [3:0]; outputs are {right,left,down,up}
            raw  = {word[0], word[1], word[2], word[3]};
            fire = word[4];
            st   = word[5];
            if (p == 0) begin
                raw  = raw | {key_q[K_P1R], key_q[K_P1L], key_q[K_P1D], key_q[K_P1U]};
                fire = fire | key_q[K_P1FA] | key_q[K_P1FB];
                st   = st | key_q[K_S1A] | key_q[K_S1B];
            end else if (p == 1) begin
                raw  = raw | {key_q[K_P2R], key_q[K_P2L], key_q[K_P2D], key_q[K_P2U]};
                fire = fire | key_q[K_P2F];
                st   = st | key_q[K_S2A] | key_q[K_S2B] | joy_any[6];
            end
            case (rot)
                2'd1:    rd = {raw[0], raw[1], raw[3], raw[2]};
                2'd2:    rd = {raw[1], raw[0], raw[2], raw[3]};
                2'd3:    rd = {raw[2], raw[3], raw[0], raw[1]};
                default: rd = raw;
            endcase
            if (socd) begin
                if (rd[0] && rd[1]) rd[1:0] = 2'b00;
                if (rd[2] && rd[3]) rd[3:2] = 2'b00;
            end
            dir_nx[4*p +: 4] = rd;
            fire_nx[p]       = fire;
            start_nx[p]      = st;
        end
    end

    assign coin_req[0] = key_q[K_C0] | joy_any[7];
    assign coin_req[1] = key_q[K_C1];

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            st_d[k]  = st_q[k];
            cnt_d[k] = cnt_q[k];
            case (st_q[k])
                C_IDLE: begin
                    if (armed_q && coin_req[k] && !req_q[k]) begin
                        st_d[k]  = C_ACTIVE;
                        cnt_d[k] = COIN_PULSE - 16'd1;
                    end
                end
                default: begin
                    // a held request keeps the slot active past the minimum width
                    if (cnt_q[k] != 16'd0)
                        cnt_d[k] = cnt_q[k] - 16'd1;
                    else if (!coin_req[k])
                        st_d[k] = C_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            req_q <= '0;
            for (int k = 0; k < 2; k++) begin
                st_q[k]  <= C_IDLE;
                cnt_q[k] <= '0;
            end
        end else begin
            req_q <= coin_req;
            for (int k = 0; k < 2; k++) begin
                st_q[k]  <= st_d[k];
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dir_o   <= {(4*PLAYERS){INV}};
            fire_o  <= {PLAYERS{INV}};
            start_o <= {PLAYERS{INV}};
            coin_o  <= {2{INV}};
        end else begin
            dir_o   <= dir_nx ^ {(4*PLAYERS){INV}};
            fire_o  <= fire_nx ^ {PLAYERS{INV}};
            start_o <= start_nx ^ {PLAYERS{INV}};
            coin_o  <= {st_d[1] == C_ACTIVE, st_d[0] == C_ACTIVE} ^ {2{INV}};
        end
    end

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Directed bench: instance A (2 players, shared joy, active-low, short coin pulse),
// instance B (4 players, separate joy, active-high).
module tb_arcade_input_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset;

    logic [10:0] ps2_key_a;
    logic        kbd_clear_a;
    logic [31:0] joystick_a;
    logic [1:0]  rot_a;
    logic        socd_a;
    logic [7:0]  dir_o_a;
    logic [1:0]  fire_o_a;
    logic [1:0]  start_o_a;
    logic [1:0]  coin_o_a;

    logic [10:0] ps2_key_b;
    logic        kbd_clear_b;
    logic [63:0] joystick_b;
    logic [1:0]  rot_b;
    logic        socd_b;
    logic [15:0] dir_o_b;
    logic [3:0]  fire_o_b;
    logic [3:0]  start_o_b;
    logic [1:0]  coin_o_b;

    int n_checks = 0;
    int n_fail   = 0;
    bit tog      = 1'b0;

    always #5 clk_sys = ~clk_sys;

    arcade_input_ctrl #(
        .PLAYERS(2), .COIN_PULSE(16'd4), .ACTIVE_LOW(1), .SHARED_JOY(1)
    ) dut_a (
        .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key_a), .kbd_clear(kbd_clear_a),
        .joystick(joystick_a), .rot(rot_a), .socd(socd_a),
        .dir_o(dir_o_a), .fire_o(fire_o_a), .start_o(start_o_a), .coin_o(coin_o_a)
    );

    arcade_input_ctrl #(
        .PLAYERS(4), .COIN_PULSE(16'd4), .ACTIVE_LOW(0), .SHARED_JOY(0)
    ) dut_b (
        .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key_b), .kbd_clear(kbd_clear_b),
        .joystick(joystick_b), .rot(rot_b), .socd(socd_b),
        .dir_o(dir_o_b), .fire_o(fire_o_b), .start_o(start_o_b), .coin_o(coin_o_b)
    );

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send_key(input bit pressed, input bit ext, input logic [7:0] code);
        tog = ~tog;
        ps2_key_a = {tog, pressed, ext, code};
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tog = 1'b1;
        ps2_key_a = {1'b1, 1'b1, 1'b1, 8'h75};
        kbd_clear_a = 1'b0; joystick_a = '0; rot_a = 2'd0; socd_a = 1'b0;
        ps2_key_b = '0; kbd_clear_b = 1'b0; joystick_b = '0; rot_b = 2'd0; socd_b = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (dir_o_a !== 8'hFF) begin n_fail++; $display("FAIL reset_dir_a: got %h expected %h", dir_o_a, 8'hFF); end
        n_checks++;
        if ({fire_o_a, start_o_a, coin_o_a} !== 6'h3F) begin n_fail++; $display("FAIL reset_fsc_a: got %h expected %h", {fire_o_a, start_o_a, coin_o_a}, 6'h3F); end
        n_checks++;
        if ({dir_o_b, fire_o_b, start_o_b, coin_o_b} !== 26'h0) begin n_fail++; $display("FAIL reset_b: got %h expected %h", {dir_o_b, fire_o_b, start_o_b, coin_o_b}, 26'h0); end
        reset = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (dir_o_a !== 8'hFF) begin n_fail++; $display("FAIL reset_no_spurious: got %h expected %h", dir_o_a, 8'hFF); end
    endtask

    task automatic test_key_up();
        send_key(1'b1, 1'b1, 8'h75);
        tick();
        n_checks++;
        if (dir_o_a !== 8'hFF) begin n_fail++; $display("FAIL key_latency1: got %h expected %h", dir_o_a, 8'hFF); end
        tick();
        n_checks++;
        if (dir_o_a !== 8'hFE) begin n_fail++; $display("FAIL key_up_press: got %h expected %h", dir_o_a, 8'hFE); end
        send_key(1'b0, 1'b1, 8'h75);
        repeat (2) tick();
        n_checks++;
        if (dir_o_a !== 8'hFF) begin n_fail++; $display("FAIL key_up_release: got %h expected %h", dir_o_a, 8'hFF); end
        send_key(1'b1, 1'b0, 8'h75);
        repeat (2) tick();
        n_checks++;
        if (dir_o_a !== 8'hFF) begin n_fail++; $display("FAIL key_nonext_ignored: got %h expected %h", dir_o_a, 8'hFF); end
        send_key(1'b0, 1'b0, 8'h75);
        repeat (2) tick();
    endtask

    task automatic test_rot();
        logic [1:0] rots [4];
        logic [7:0] exps [4];
        rots = '{2'd1, 2'd2, 2'd3, 2'd0};
        exps = '{8'hEE, 8'hDD, 8'h77, 8'hBB};
        joystick_a = 32'h0000_0002;
        for (int i = 0; i < 4; i++) begin
            rot_a = rots[i];
            tick();
            n_checks++;
            if (dir_o_a !== exps[i]) begin n_fail++; $display("FAIL rot_left rot=%0d: got %h expected %h", rots[i], dir_o_a, exps[i]); end
        end
        joystick_a = '0;
        rot_a = 2'd0;
        tick();
    endtask

    task automatic test_socd();
        send_key(1'b1, 1'b1, 8'h75);
        repeat (2) tick();
        socd_a = 1'b1;
        joystick_a = 32'h0000_0004;
        tick();
        n_checks++;
        if (dir_o_a !== 8'hDF) begin n_fail++; $display("FAIL socd_on: got %h expected %h", dir_o_a, 8'hDF); end
        socd_a = 1'b0;
        tick();
        n_checks++;
        if (dir_o_a !== 8'hDC) begin n_fail++; $display("FAIL socd_off: got %h expected %h", dir_o_a, 8'hDC); end
        send_key(1'b0, 1'b1, 8'h75);
        joystick_a = '0;
        repeat (2) tick();
        n_checks++;
        if (dir_o_a !== 8'hFF) begin n_fail++; $display("FAIL socd_cleanup: got %h expected %h", dir_o_a, 8'hFF); end
    endtask

    task automatic test_fire_start();
        send_key(1'b1, 1'b0, 8'h29);
        repeat (2) tick();
        n_checks++;
        if (fire_o_a !== 2'b10) begin n_fail++; $display("FAIL fire_p1_press: got %b expected %b", fire_o_a, 2'b10); end
        send_key(1'b1, 1'b0, 8'h29);
        repeat (2) tick();
        n_checks++;
        if (fire_o_a !== 2'b10) begin n_fail++; $display("FAIL fire_p1_repeat: got %b expected %b", fire_o_a, 2'b10); end
        send_key(1'b0, 1'b0, 8'h29);
        repeat (2) tick();
        n_checks++;
        if (fire_o_a !== 2'b11) begin n_fail++; $display("FAIL fire_p1_release: got %b expected %b", fire_o_a, 2'b11); end
        send_key(1'b1, 1'b0, 8'h16);
        repeat (2) tick();
        n_checks++;
        if (start_o_a !== 2'b10) begin n_fail++; $display("FAIL start1_key: got %b expected %b", start_o_a, 2'b10); end
        send_key(1'b0, 1'b0, 8'h16);
        joystick_a = 32'h0000_0040;
        repeat (2) tick();
        n_checks++;
        if (start_o_a !== 2'b01) begin n_fail++; $display("FAIL start2_joy: got %b expected %b", start_o_a, 2'b01); end
        joystick_a = '0;
        tick();
    endtask

    task automatic test_kbd_clear();
        send_key(1'b1, 1'b0, 8'h1C);
        repeat (2) tick();
        n_checks++;
        if (fire_o_a !== 2'b01) begin n_fail++; $display("FAIL p2_fire_press: got %b expected %b", fire_o_a, 2'b01); end
        kbd_clear_a = 1'b1;
        tick();
        kbd_clear_a = 1'b0;
        tick();
        n_checks++;
        if (fire_o_a !== 2'b11) begin n_fail++; $display("FAIL kbd_clear: got %b expected %b", fire_o_a, 2'b11); end
        kbd_clear_a = 1'b1;
        send_key(1'b1, 1'b0, 8'h1C);
        tick();
        kbd_clear_a = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (fire_o_a !== 2'b11) begin n_fail++; $display("FAIL kbd_clear_priority: got %b expected %b", fire_o_a, 2'b11); end
    endtask

    task automatic test_coin();
        int n;
        send_key(1'b1, 1'b0, 8'h2E);
        tick();
        send_key(1'b0, 1'b0, 8'h2E);
        tick();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (coin_o_a[0] === 1'b0) n++;
            tick();
        end
        n_checks++;
        if (n != 4) begin n_fail++; $display("FAIL coin_pulse_width: got %0d cycles expected %0d", n, 4); end

        send_key(1'b1, 1'b0, 8'h2E);
        tick();
        send_key(1'b0, 1'b0, 8'h2E);
        tick();
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (coin_o_a[0] === 1'b0) n++;
            if (i == 1) send_key(1'b1, 1'b0, 8'h2E);
            if (i == 2) send_key(1'b0, 1'b0, 8'h2E);
            tick();
        end
        n_checks++;
        if (n != 4) begin n_fail++; $display("FAIL coin_no_retrigger: got %0d cycles expected %0d", n, 4); end
        n_checks++;
        if (coin_o_a[1] !== 1'b1) begin n_fail++; $display("FAIL coin1_idle: got %b expected %b", coin_o_a[1], 1'b1); end

        joystick_a = 32'h0000_0080;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (coin_o_a[0] === 1'b0) n++;
            if (i == 7) joystick_a = '0;
        end
        n_checks++;
        if (n != 8) begin n_fail++; $display("FAIL coin_hold: got %0d cycles expected %0d", n, 8); end

        send_key(1'b1, 1'b0, 8'h36);
        tick();
        send_key(1'b0, 1'b0, 8'h36);
        tick();
        n_checks++;
        if (coin_o_a !== 2'b01) begin n_fail++; $display("FAIL coin1_key: got %b expected %b", coin_o_a, 2'b01); end
        repeat (8) tick();
    endtask

    task automatic test_reset_mid_pulse();
        int n;
        joystick_a = 32'h0000_0080;
        tick();
        joystick_a = '0;
        n_checks++;
        if (coin_o_a !== 2'b10) begin n_fail++; $display("FAIL pulse_started: got %b expected %b", coin_o_a, 2'b10); end
        tick();
        reset = 1'b1;
        #1;
        n_checks++;
        if (coin_o_a !== 2'b11) begin n_fail++; $display("FAIL reset_abort: got %b expected %b", coin_o_a, 2'b11); end
        tick();
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (coin_o_a !== 2'b11) n++;
        end
        n_checks++;
        if (n != 0) begin n_fail++; $display("FAIL no_resume: got %0d active cycles expected %0d", n, 0); end
    endtask

    task automatic test_players4();
        joystick_b = 64'h0010_0000_0000_0000;
        tick();
        n_checks++;
        if (fire_o_b !== 4'b1000) begin n_fail++; $display("FAIL p4_fire_only: got %b expected %b", fire_o_b, 4'b1000); end
        n_checks++;
        if (dir_o_b !== 16'h0000) begin n_fail++; $display("FAIL p4_no_dir: got %h expected %h", dir_o_b, 16'h0000); end
        joystick_b = 64'h0000_0028_0000_0000;
        tick();
        n_checks++;
        if (dir_o_b !== 16'h0100) begin n_fail++; $display("FAIL p3_up: got %h expected %h", dir_o_b, 16'h0100); end
        n_checks++;
        if (start_o_b !== 4'b0100) begin n_fail++; $display("FAIL p3_start: got %b expected %b", start_o_b, 4'b0100); end
        joystick_b = 64'h0000_0000_0080_0000;
        tick();
        n_checks++;
        if (coin_o_b !== 2'b01) begin n_fail++; $display("FAIL b_coin_any_joy: got %b expected %b", coin_o_b, 2'b01); end
        joystick_b = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_key_up();
        test_rot();
        test_socd();
        test_fire_start();
        test_kbd_clear();
        test_coin();
        test_reset_mid_pulse();
        test_players4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
